// File: rtl/serial_subtractor.sv
// Bit-serial a - b: one full-subtractor cell plus a borrow flop, LSB first.
// Result {borrow, diff} is the WIDTH+1 bit two's complement difference.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   d
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic [WIDTH-1:0] sd_next;
    logic             br;
    logic             br_next;
    logic             dbit;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             load;
    logic             step;

    // Full-subtractor cell on the current LSBs.
    always_comb begin
        dbit    = sa[0] ^ sb[0] ^ br;
        br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        sd_next = {dbit, sd[WIDTH-1:1]};
        last    = (cnt == CW'(WIDTH - 1));
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa  <= '0;
            sb  <= '0;
            sd  <= '0;
            br  <= 1'b0;
            cnt <= '0;
            d   <= '0;
        end else if (load) begin
            sa  <= a;
            sb  <= b;
            br  <= 1'b0;
            cnt <= '0;
        end else if (step) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sd  <= sd_next;
            br  <= br_next;
            cnt <= cnt + CW'(1);
            // d only changes on the edge that completes an operation.
            if (last) begin
                d <= {br_next, sd_next};
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: cycle model of busy/done/d plus directed
// vectors with literal expected results and an exhaustive WIDTH=4 sweep.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W:0]   d;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .d    (d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: an op accepted at edge e completes at edge e+W,
    // busy in between; start is accepted unless an op is mid-flight.
    int         n = 0;
    int         e = 0;
    bit         pv = 0;
    logic [W:0] val = '0;
    logic [W:0] md = '0;
    bit         mbusy = 0;
    bit         mdone = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv    = 0;
            md    = '0;
            mbusy = 0;
            mdone = 0;
        end else begin
            bit acc;
            n++;
            acc = start && !(pv && n <= e + W);
            if (pv && n == e + W) md = val;
            if (acc) begin
                e   = n;
                val = {1'b0, a} - {1'b0, b};
                pv  = 1;
            end
            mbusy = pv && n >= e && n < e + W;
            mdone = pv && n == e + W;
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            chk("model_busy", 32'(busy), 32'(mbusy));
            chk("model_done", 32'(done), 32'(mdone));
            chk("model_d", 32'(d), 32'(md));
        end
    end

    // Starts one op, returns cycles to done (0 on timeout) and d then.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                          output int lat, output logic [W:0] res);
        @(negedge clk);
        a     = xa;
        b     = xb;
        start = 1'b1;
        lat   = 0;
        res   = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done) begin
                lat = k;
                res = d;
                break;
            end
        end
        if (lat == 0) chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic op_lit(input string nm, input logic [W-1:0] xa,
                          input logic [W-1:0] xb, input logic [W:0] exp);
        int         lat;
        logic [W:0] res;
        run_op(xa, xb, lat, res);
        chk({nm, "_lat"}, 32'(lat), 32'(W + 1));
        chk({nm, "_d"}, 32'(res), 32'(exp));
    endtask

    initial begin
        int         lat;
        int         pulses;
        int         gap;
        logic [W:0] res;
        logic [W:0] xp;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_d", 32'(d), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors with hand-computed results.
        op_lit("9m3", 4'd9, 4'd3, 5'b00110);
        op_lit("3m9", 4'd3, 4'd9, 5'b11010);
        op_lit("0m15", 4'd0, 4'd15, 5'b10001);
        op_lit("15m0", 4'd15, 4'd0, 5'b01111);
        op_lit("7m7", 4'd7, 4'd7, 5'b00000);

        // Reset after two bits of 9-3: immediate clear, no done later.
        a = 4'd9;
        b = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_d", 32'(d), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("abort_no_done", 32'(pulses), 32'd0);
        op_lit("after_abort", 4'd9, 4'd3, 5'b00110);

        // Start while busy is ignored.
        a = 4'd9;
        b = 4'd3;
        start = 1'b1;
        pulses = 0;
        res = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 2) begin
                a = 4'd1;
                b = 4'd2;
                start = 1'b1;
            end
            if (done) begin
                pulses++;
                res = d;
            end
        end
        chk("busy_start_pulses", 32'(pulses), 32'd1);
        chk("busy_start_d", 32'(res), 32'(5'b00110));

        // start held high: back-to-back 5-4 then 4-5.
        a = 4'd5;
        b = 4'd4;
        start = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("b2b_lat1", 32'(lat), 32'(W + 1));
        chk("b2b_d1", 32'(d), 32'(5'b00001));
        a = 4'd4;
        b = 4'd5;
        gap = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                gap = k;
                break;
            end
        end
        start = 1'b0;
        chk("b2b_gap", 32'(gap), 32'(W + 1));
        chk("b2b_d2", 32'(d), 32'(5'b11111));
        @(negedge clk);

        // Exhaustive sweep against plain modular arithmetic.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                xp = 5'((i - j) & 32'h1F);
                run_op(4'(i), 4'(j), lat, res);
                chk("sweep_lat", 32'(lat), 32'(W + 1));
                chk("sweep_d", 32'(res), 32'(xp));
            end
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
